// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter slice.
package rr_mux_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;
endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Addressed word mux: selects word addr out of INPUT_COUNT packed words,
// optionally through an output register.
module addressed_mux import rr_mux_arbiter_pkg::*; #(
  parameter int WORD_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 2,
  parameter int INPUT_COUNT = 4,
  parameter bit REGISTERED  = FALSE
) (
  input  logic                              clock,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [WORD_WIDTH*INPUT_COUNT-1:0] data_in,
  output logic [WORD_WIDTH-1:0]             data_out
);
  logic [WORD_WIDTH-1:0] sel;

  // Compare-and-select keeps out-of-range addresses from reading past data_in.
  always_comb begin
    sel = '0;
    for (int i = 0; i < INPUT_COUNT; i++)
      if (addr == ADDR_WIDTH'(i)) sel = data_in[i*WORD_WIDTH +: WORD_WIDTH];
  end

  generate
    if (REGISTERED) begin : g_reg
      always_ff @(posedge clock) data_out <= sel;
    end else begin : g_comb
      logic unused_clock;
      assign unused_clock = clock;
      assign data_out     = sel;
    end
  endgenerate
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter granting one of INPUT_COUNT valid/ready requesters
// onto a shared addressed mux, back-to-back when another requester waits.
module rr_mux_arbiter import rr_mux_arbiter_pkg::*; #(
  parameter int WORD_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 2,
  parameter int INPUT_COUNT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [INPUT_COUNT-1:0]            in_valid,
  input  logic [WORD_WIDTH*INPUT_COUNT-1:0] in_data,
  output logic [INPUT_COUNT-1:0]            in_ready,
  output logic                              out_valid,
  output logic [WORD_WIDTH-1:0]             out_data,
  input  logic                              out_ready,
  output logic [ADDR_WIDTH-1:0]             grant_addr
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(INPUT_COUNT-1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   rr_ptr;
  logic [INPUT_COUNT-1:0]  served_oh;
  logic                    handshake;
  logic [ADDR_WIDTH:0]     idle_pick, hs_pick;

  // Wrap at INPUT_COUNT-1 so non-power-of-two counts never reach unused indices.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  // Returns {found, index} of the first set bit at or after start, wrapping.
  function automatic logic [ADDR_WIDTH:0] pick(input logic [INPUT_COUNT-1:0] vec,
                                               input logic [ADDR_WIDTH-1:0]  start);
    logic [ADDR_WIDTH-1:0] idx, res;
    logic                  found;
    idx   = start;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (!found && vec[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return {found, res};
  endfunction

  generate
    for (genvar i = 0; i < INPUT_COUNT; i++) begin : g_lane
      assign served_oh[i] = (grant_addr == ADDR_WIDTH'(i));
      assign in_ready[i]  = handshake && served_oh[i];
    end
  endgenerate

  assign handshake = (state == HOLD) && out_ready;

  // The just-served requester is masked so it always sits out one cycle.
  always_comb begin
    idle_pick = pick(in_valid, rr_ptr);
    hs_pick   = pick(in_valid & ~served_oh, wrap_inc(grant_addr));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_addr <= '0;
      rr_ptr     <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (idle_pick[ADDR_WIDTH]) begin
          grant_addr <= idle_pick[ADDR_WIDTH-1:0];
          state      <= HOLD;
          out_valid  <= 1'b1;
        end
        HOLD: if (out_ready) begin
          rr_ptr <= wrap_inc(grant_addr);
          if (hs_pick[ADDR_WIDTH]) begin
            grant_addr <= hs_pick[ADDR_WIDTH-1:0];
          end else begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  addressed_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INPUT_COUNT(INPUT_COUNT),
    .REGISTERED (FALSE)
  ) u_mux (
    .clock   (clock),
    .addr    (grant_addr),
    .data_in (in_data),
    .data_out(out_data)
  );
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench: a 4-input and a 3-input arbiter sharing clock and reset.
module tb_rr_mux_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  iv4 = '0, ir4;
  logic [31:0] id4 = '0;
  logic        ordy4 = 1'b0, ov4;
  logic [7:0]  od4;
  logic [1:0]  ga4;

  logic [2:0]  iv3 = '0, ir3;
  logic [23:0] id3 = '0;
  logic        ordy3 = 1'b0, ov3;
  logic [7:0]  od3;
  logic [1:0]  ga3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rr_mux_arbiter #(.WORD_WIDTH(8), .ADDR_WIDTH(2), .INPUT_COUNT(4)) u4 (
    .clock(clock), .reset(reset), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(ordy4), .grant_addr(ga4));

  rr_mux_arbiter #(.WORD_WIDTH(8), .ADDR_WIDTH(2), .INPUT_COUNT(3)) u3 (
    .clock(clock), .reset(reset), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(ordy3), .grant_addr(ga3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus must hold the granted requester's request while stalled.
  always @(negedge clock) begin
    #2;
    if (!reset && ov4 && !ordy4) chk("hold_stable", {31'd0, iv4[ga4]}, 32'd1);
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  initial begin
    int eg4[6];
    int eg3[4];
    eg4 = '{0, 1, 2, 3, 0, 1};
    eg3 = '{0, 1, 2, 0};

    // Reset state
    cyc(); cyc();
    chk("rst_ov", {31'd0, ov4}, 32'd0);
    chk("rst_ga", {30'd0, ga4}, 32'd0);
    chk("rst_ir", {28'd0, ir4}, 32'd0);
    reset = 1'b0;

    // Single request on 1
    id4 = {8'h00, 8'h00, 8'hA5, 8'h00};
    iv4 = 4'b0010; ordy4 = 1'b1;
    cyc();
    chk("single_ov", {31'd0, ov4}, 32'd1);
    chk("single_ga", {30'd0, ga4}, 32'd1);
    chk("single_od", {24'd0, od4}, 32'hA5);
    chk("single_ir", {28'd0, ir4}, 32'b0010);
    iv4 = 4'b0000;
    cyc();
    chk("single_drop_ov", {31'd0, ov4}, 32'd0);
    chk("single_drop_ir", {28'd0, ir4}, 32'd0);

    // Round-robin rotation from a fresh reset
    reset = 1'b1; cyc(); reset = 1'b0;
    id4 = {8'h44, 8'h33, 8'h22, 8'h11};
    iv4 = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("rot_ga%0d", k), {30'd0, ga4}, eg4[k]);
      chk($sformatf("rot_ov%0d", k), {31'd0, ov4}, 32'd1);
      chk($sformatf("rot_od%0d", k), {24'd0, od4}, 32'h11 * (eg4[k] + 1));
      chk($sformatf("rot_ir%0d", k), {28'd0, ir4}, 32'd1 << eg4[k]);
    end
    iv4 = 4'b0000;
    cyc();
    chk("rot_end_ov", {31'd0, ov4}, 32'd0);

    // Backpressure on grant 2 (rr_ptr now 2)
    ordy4 = 1'b0; iv4 = 4'b0100;
    cyc();
    chk("bp_grant", {30'd0, ga4}, 32'd2);
    iv4 = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("bp_ga%0d", k), {30'd0, ga4}, 32'd2);
      chk($sformatf("bp_ir%0d", k), {28'd0, ir4}, 32'd0);
      chk($sformatf("bp_ov%0d", k), {31'd0, ov4}, 32'd1);
      iv4 = (k % 2 == 0) ? 4'b0100 : 4'b1101;
    end
    iv4 = 4'b1100; ordy4 = 1'b1;
    #1;
    chk("bp_release_ir", {28'd0, ir4}, 32'b0100);
    cyc();
    chk("bp_next_ga", {30'd0, ga4}, 32'd3);
    chk("bp_next_ov", {31'd0, ov4}, 32'd1);
    iv4 = 4'b0000;
    cyc();
    chk("bp_idle_ov", {31'd0, ov4}, 32'd0);

    // Lone requester 3: one word per two cycles
    iv4 = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("lone_ov%0d", k), {31'd0, ov4}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("lone_ir%0d", k), {28'd0, ir4}, (k % 2 == 0) ? 32'b1000 : 32'd0);
    end

    // Async reset between edges while holding
    iv4 = 4'b1111;
    cyc();
    chk("ar_pre_ov", {31'd0, ov4}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_ov", {31'd0, ov4}, 32'd0);
    chk("ar_ir", {28'd0, ir4}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("ar_first_ga", {30'd0, ga4}, 32'd0);
    chk("ar_first_ov", {31'd0, ov4}, 32'd1);
    iv4 = 4'b0000;

    // Non-power-of-two wrap on the 3-input arbiter
    id3 = {8'hA2, 8'hA1, 8'hA0};
    iv3 = 3'b111; ordy3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("n3_ga%0d", k), {30'd0, ga3}, eg3[k]);
      chk($sformatf("n3_od%0d", k), {24'd0, od3}, 32'hA0 + eg3[k]);
      chk($sformatf("n3_ir%0d", k), {29'd0, ir3}, 32'd1 << eg3[k]);
    end
    iv3 = 3'b000;
    cyc();
    chk("n3_end_ov", {31'd0, ov3}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one addressed word multiplexer among INPUT_COUNT requesters, each with a valid/ready handshake. It registers the grant index, drives it as the mux address, and presents the selected word downstream with out_valid/out_ready. It sits in front of any shared single-port consumer: memory write port, I/O port, or a shared functional unit.

Parameters:
WORD_WIDTH, 0, width of each requester's data word
ADDR_WIDTH, 0, width of grant index; 2**ADDR_WIDTH >= INPUT_COUNT required
INPUT_COUNT, 0, number of requesters, 2..2**ADDR_WIDTH, need not be a power of two

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  INPUT_COUNT  per-requester request; bit i belongs to requester i
in_data  input  WORD_WIDTH*INPUT_COUNT  packed words; requester i at [i*WORD_WIDTH +: WORD_WIDTH]
in_ready  output  INPUT_COUNT  one-hot acknowledge; high only in the cycle requester i's word is accepted downstream
out_valid  output  1  a granted word is presented
out_data  output  WORD_WIDTH  word of the granted requester; combinational from in_data through the mux at grant_addr
out_ready  input  1  downstream accepts out_data when out_valid && out_ready
grant_addr  output  ADDR_WIDTH  registered index of the current grant, the mux address

Behaviour:
- Reset values: state=IDLE, grant_addr=0, rr_ptr=0, out_valid=0, in_ready=0. out_data then shows in_data word 0, which is don't-care.
- State is one register: IDLE or HOLD. out_valid = (state==HOLD), registered.
- Pick function: search in_valid from index rr_ptr upward, wrapping INPUT_COUNT-1 -> 0. The result is the first set bit; there is no match if the searched vector is zero.
- IDLE: if any in_valid, grant_addr <= pick(in_valid) and state <= HOLD. Otherwise remain IDLE.
- HOLD without handshake (out_ready=0):
  - grant_addr and state hold.
  - Other requesters' in_valid changes are ignored.
  - The granted requester must keep in_valid and in_data stable; the bench asserts this.
- HOLD with handshake (out_ready=1), same cycle:
  - in_ready[grant_addr]=1, all other in_ready bits 0.
  - rr_ptr <= grant_addr+1, wrapping INPUT_COUNT-1 -> 0.
- Back-to-back on handshake:
  - Compute pick over in_valid with bit grant_addr masked off, searching from grant_addr+1.
  - On a match: grant_addr <= match and state stays HOLD. There is no bubble and out_valid stays 1.
  - On no match: state <= IDLE.
  - The just-served requester always sees one idle cycle before its next grant. A lone requester therefore gets at most one word per two cycles.
- Fairness: any continuously asserting requester is granted within INPUT_COUNT-1 other grants.
- Latency: in_valid rising in IDLE leads to out_valid=1 on the next cycle; minimum handshake latency is 1 cycle.
- in_ready is combinational: (state==HOLD) && out_ready && (index==grant_addr). There is no combinational path from in_valid to in_ready.
- Width rules:
  - Index compare and increment are done at ADDR_WIDTH bits with explicit wrap at INPUT_COUNT-1, not at 2**ADDR_WIDTH-1.
  - grant_addr never holds a value >= INPUT_COUNT.
- Simultaneous events: only requesters already asserting in_valid in a cycle are eligible that cycle; there is no lookahead.
- Reset asserted mid-HOLD: out_valid drops and in_ready goes 0 asynchronously. The word is not accepted, and the requester re-requests after reset.
- Reset release: first grant search starts at index 0.

Decomposition:
- Shared package/header: state encodings (IDLE, HOLD) and the TRUE/FALSE constants.
- One natural sub-module: the existing Addressed_Mux, instantiated combinationally (REGISTERED=FALSE) with addr=grant_addr, data_in=in_data, data_out=out_data.
- The pick/wrap logic stays local as a function.

Test Plan:
- Single request: N=4, W=8, reset then in_valid=0010, in_data[1]=8'hA5, out_ready=1 -> cycle+1 out_valid=1, grant_addr=1, out_data=A5, in_ready=0010; next cycle out_valid=0 if in_valid dropped.
- Round-robin rotation: in_valid=1111 held, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles with out_valid continuously 1 and one in_ready bit per cycle.
- Backpressure: grant on 2, out_ready=0 for 5 cycles while in_valid toggles bits 0/3 -> grant_addr stays 2, in_ready=0000; out_ready=1 -> in_ready=0100, next grant 3 if set, else 0.
- Non-power-of-two wrap: N=3, ADDR_WIDTH=2, in_valid=111 -> grants 0,1,2,0; grant_addr never 3.
- Lone requester repeat: in_valid=1000 held, out_ready=1 -> handshakes on every second cycle with out_valid pattern 1,0,1,0.
- Async reset mid-HOLD: assert reset between clock edges while out_valid=1 -> out_valid=0 and in_ready=0000 before the next edge; after release with in_valid=1111, first grant is 0.
